// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: receive-side decoder for a multiplexed seven-segment scan.
// Registers {dig,ssd}, waits for SETTLE_CYC consecutive stable edges, then
// decodes the segment pattern of the selected digit into a per-digit hex image.
// Optional watchdog enabled by defining SSD_SCAN_TIMEOUT_EN (adds the stall port).
module ssd_scan_decoder #(
    parameter int N_DIG       = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DIG-1:0]   dig,
    input  logic [7:0]         ssd,
    input  logic               clr,
    output logic [4*N_DIG-1:0] code_out,
    output logic [N_DIG-1:0]   dp_out,
    output logic [N_DIG-1:0]   seen,
    output logic [N_DIG-1:0]   bad_seg,
    output logic               frame_done,
    output logic               onehot_err
`ifdef SSD_SCAN_TIMEOUT_EN
    ,
    output logic               stall
`endif
);

    localparam int IDXW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int SW   = N_DIG + 8;

    // Segment pattern (a..g, a in the MSB) to {valid, hex code}.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b1111110: res = {1'b1, 4'h0};
            7'b0110000: res = {1'b1, 4'h1};
            7'b1101101: res = {1'b1, 4'h2};
            7'b1111001: res = {1'b1, 4'h3};
            7'b0110011: res = {1'b1, 4'h4};
            7'b1011011: res = {1'b1, 4'h5};
            7'b1011111: res = {1'b1, 4'h6};
            7'b1110000: res = {1'b1, 4'h7};
            7'b1111111: res = {1'b1, 4'h8};
            7'b1111011: res = {1'b1, 4'h9};
            7'b1110111: res = {1'b1, 4'hA};
            7'b0011111: res = {1'b1, 4'hB};
            7'b1001110: res = {1'b1, 4'hC};
            7'b0111101: res = {1'b1, 4'hD};
            7'b1001111: res = {1'b1, 4'hE};
            7'b1000111: res = {1'b1, 4'hF};
            default:    res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [SW-1:0]      samp_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [4*N_DIG-1:0] code_q, code_d;
    logic [N_DIG-1:0]   dp_q, dp_d;
    logic [N_DIG-1:0]   seen_q, seen_d;
    logic [N_DIG-1:0]   bad_q, bad_d;
    logic               frame_q, frame_d;
    logic               oherr_q, oherr_d;
    logic [IDXW-1:0]    last_q, last_d;
    logic               lastv_q, lastv_d;

    logic               same_s;
    logic               settle_s;
    logic               any_s;
    logic               multi_s;
    logic [IDXW-1:0]    idx_s;
    logic [4:0]         dec_s;
    logic               cap_s;

`ifdef SSD_SCAN_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               stall_q, stall_d;
`endif

    // Stability detection: counter advances while the input matches the last sample.
    always_comb begin
        same_s   = ({dig, ssd} == samp_q);
        settle_s = same_s && (cnt_q == 4'(SETTLE_CYC - 1));
        if (!same_s) begin
            cnt_d = 4'd0;
        end else if (cnt_q == 4'(SETTLE_CYC)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // One-hot analysis of the digit select and segment decode.
    always_comb begin
        any_s   = 1'b0;
        multi_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N_DIG; i++) begin
            multi_s = multi_s | (any_s & dig[i]);
            any_s   = any_s | dig[i];
            if (dig[i]) begin
                idx_s = IDXW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        dec_s = seg_decode(ssd[7:1]);
        cap_s = settle_s && any_s && !multi_s && !clr;
    end

    // Next state of the captured image, frame tracking and sticky error.
    always_comb begin
        code_d  = code_q;
        dp_d    = dp_q;
        seen_d  = seen_q;
        bad_d   = bad_q;
        oherr_d = oherr_q;
        last_d  = last_q;
        lastv_d = lastv_q;
        frame_d = 1'b0;
        if (clr) begin
            code_d  = '0;
            dp_d    = '0;
            seen_d  = '0;
            bad_d   = '0;
            oherr_d = 1'b0;
            lastv_d = 1'b0;
        end else if (settle_s && multi_s) begin
            // Several digits selected at once: flag it, capture nothing.
            oherr_d = 1'b1;
        end else if (cap_s) begin
            dp_d[idx_s]   = ssd[0];
            seen_d[idx_s] = 1'b1;
            if (dec_s[4]) begin
                code_d[4*idx_s +: 4] = dec_s[3:0];
                bad_d[idx_s]         = 1'b0;
            end else begin
                bad_d[idx_s] = 1'b1;
            end
            // Same or lower index than the previous capture means the scan wrapped.
            frame_d = lastv_q && (idx_s <= last_q);
            last_d  = idx_s;
            lastv_d = 1'b1;
        end else begin
            frame_d = 1'b0;
        end
`ifdef SSD_SCAN_TIMEOUT_EN
        if (!clr && !cap_s && (wd_q == WDW'(TIMEOUT_CYC - 1))) begin
            seen_d  = '0;
            lastv_d = 1'b0;
        end else begin
            seen_d = seen_d;
        end
`endif
    end

`ifdef SSD_SCAN_TIMEOUT_EN
    // Watchdog: clocks since the last capture or clear; blank dwells keep counting.
    always_comb begin
        stall_d = 1'b0;
        if (clr || cap_s) begin
            wd_d = '0;
        end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
            wd_d    = '0;
            stall_d = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`endif

    // State registers for the sample stage and the captured image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q  <= '0;
            cnt_q   <= 4'd0;
            code_q  <= '0;
            dp_q    <= '0;
            seen_q  <= '0;
            bad_q   <= '0;
            frame_q <= 1'b0;
            oherr_q <= 1'b0;
            last_q  <= '0;
            lastv_q <= 1'b0;
        end else begin
            samp_q  <= {dig, ssd};
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            dp_q    <= dp_d;
            seen_q  <= seen_d;
            bad_q   <= bad_d;
            frame_q <= frame_d;
            oherr_q <= oherr_d;
            last_q  <= last_d;
            lastv_q <= lastv_d;
        end
    end

    assign code_out   = code_q;
    assign dp_out     = dp_q;
    assign seen       = seen_q;
    assign bad_seg    = bad_q;
    assign frame_done = frame_q;
    assign onehot_err = oherr_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: table-driven vectors, hand sequences for the
// timing corners, and random dwells checked against a run-length model.
module tb_ssd_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  dig;
    logic [7:0]  ssd;
    logic        clr;
    logic [31:0] code_out;
    logic [7:0]  dp_out;
    logic [7:0]  seen;
    logic [7:0]  bad_seg;
    logic        frame_done;
    logic        onehot_err;
`ifdef SSD_SCAN_TIMEOUT_EN
    logic        stall;
`endif

    ssd_scan_decoder #(
        .N_DIG(8), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dig(dig), .ssd(ssd), .clr(clr),
        .code_out(code_out), .dp_out(dp_out), .seen(seen), .bad_seg(bad_seg),
        .frame_done(frame_done), .onehot_err(onehot_err)
`ifdef SSD_SCAN_TIMEOUT_EN
        , .stall(stall)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Segment table a..g for hex 0..F.
    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: how many consecutive edges has the current input been seen.
    logic [15:0] m_prev;
    int          m_run;
    logic [31:0] m_code;
    logic [7:0]  m_dp, m_seen, m_bad;
    logic        m_oherr, m_frame, m_stall;
    int          m_last;
    int          m_cyc, m_ref;

    task automatic model_reset();
        m_prev = 16'h0000; m_run = 1;
        m_code = 32'h0; m_dp = 8'h0; m_seen = 8'h0; m_bad = 8'h0;
        m_oherr = 1'b0; m_frame = 1'b0; m_stall = 1'b0; m_last = -1;
        m_ref = m_cyc;
    endtask

    task automatic model_edge(input logic [7:0] d, input logic [7:0] s, input logic c);
        int idx;
        int hex;
        bit cap;
        m_cyc++;
        if ({d, s} == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = {d, s};
        m_frame = 1'b0;
        m_stall = 1'b0;
        cap = 0;
        if (c) begin
            m_code = 32'h0; m_dp = 8'h0; m_seen = 8'h0; m_bad = 8'h0;
            m_oherr = 1'b0; m_last = -1;
        end else if (m_run == SETTLE + 1) begin
            if ($countones(d) > 1) begin
                m_oherr = 1'b1;
            end else if ($countones(d) == 1) begin
                cap = 1;
                idx = 0;
                for (int i = 0; i < 8; i++) if (d[i]) idx = i;
                hex = -1;
                for (int h = 0; h < 16; h++) if (seg_tab[h] == s[7:1]) hex = h;
                m_dp[idx] = s[0];
                m_seen[idx] = 1'b1;
                if (hex < 0) begin
                    m_bad[idx] = 1'b1;
                end else begin
                    m_bad[idx] = 1'b0;
                    m_code[4*idx +: 4] = 4'(hex);
                end
                m_frame = (m_last >= 0) && (idx <= m_last);
                m_last = idx;
            end
        end
`ifdef SSD_SCAN_TIMEOUT_EN
        if (c || cap) begin
            m_ref = m_cyc;
        end else if (m_cyc - m_ref == TIMEOUT) begin
            m_stall = 1'b1; m_seen = 8'h0; m_last = -1; m_ref = m_cyc;
        end
`endif
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("code_out", code_out, m_code);
        chk("dp_out", {24'h0, dp_out}, {24'h0, m_dp});
        chk("seen", {24'h0, seen}, {24'h0, m_seen});
        chk("bad_seg", {24'h0, bad_seg}, {24'h0, m_bad});
        chk("frame_done", {31'h0, frame_done}, {31'h0, m_frame});
        chk("onehot_err", {31'h0, onehot_err}, {31'h0, m_oherr});
`ifdef SSD_SCAN_TIMEOUT_EN
        chk("stall", {31'h0, stall}, {31'h0, m_stall});
`endif
    endtask

    // One clock: drive, let the edge happen, update the model, sample 1 time unit later.
    task automatic step(input logic [7:0] d, input logic [7:0] s, input logic c);
        dig = d; ssd = s; clr = c;
        @(posedge clk);
        model_edge(d, s, c);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [7:0]  dig;
        logic [7:0]  ssd;
        logic        clr;
        int          cyc;
        logic [31:0] code;
        logic [7:0]  seen;
        logic [7:0]  bad;
        logic        oherr;
        int          frames;
    } vec_t;

    vec_t vt [21];

    initial begin
        int frames;
        logic [7:0] d, s;
        logic       c;
        int         hold;

        // dig/ssd/clr/cycles -> code, seen, bad, onehot_err, frame_done pulses in row
        vt[0]  = '{8'h00, 8'h00, 1'b1, 1, 32'h0000_0000, 8'h00, 8'h00, 1'b0, 0};
        vt[1]  = '{8'h01, 8'hFC, 1'b0, 8, 32'h0000_0000, 8'h01, 8'h00, 1'b0, 0};
        vt[2]  = '{8'h02, 8'h60, 1'b0, 8, 32'h0000_0010, 8'h03, 8'h00, 1'b0, 0};
        vt[3]  = '{8'h04, 8'hDA, 1'b0, 8, 32'h0000_0210, 8'h07, 8'h00, 1'b0, 0};
        vt[4]  = '{8'h08, 8'hF2, 1'b0, 8, 32'h0000_3210, 8'h0F, 8'h00, 1'b0, 0};
        vt[5]  = '{8'h10, 8'h66, 1'b0, 8, 32'h0004_3210, 8'h1F, 8'h00, 1'b0, 0};
        vt[6]  = '{8'h20, 8'hB6, 1'b0, 8, 32'h0054_3210, 8'h3F, 8'h00, 1'b0, 0};
        vt[7]  = '{8'h40, 8'hBE, 1'b0, 8, 32'h0654_3210, 8'h7F, 8'h00, 1'b0, 0};
        vt[8]  = '{8'h80, 8'hE0, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[9]  = '{8'h01, 8'hFC, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 1};
        vt[10] = '{8'h02, 8'h60, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[11] = '{8'h04, 8'hDA, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[12] = '{8'h08, 8'hF2, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[13] = '{8'h10, 8'h66, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[14] = '{8'h20, 8'hB6, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[15] = '{8'h40, 8'hBE, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[16] = '{8'h80, 8'hE0, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b0, 0};
        vt[17] = '{8'h03, 8'hF2, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h00, 1'b1, 0};
        vt[18] = '{8'h02, 8'hAA, 1'b0, 8, 32'h7654_3210, 8'hFF, 8'h02, 1'b1, 1};
        vt[19] = '{8'h02, 8'hF6, 1'b0, 8, 32'h7654_3290, 8'hFF, 8'h00, 1'b1, 1};
        vt[20] = '{8'h00, 8'h00, 1'b1, 1, 32'h0000_0000, 8'h00, 8'h00, 1'b0, 0};

        rst_n = 1'b0; dig = 8'h00; ssd = 8'h00; clr = 1'b0;
        m_cyc = 0;
        model_reset();
        #23;
        rst_n = 1'b1;
        #1;
        compare_model();

        // Single dwell: capture lands exactly on the 4th stable edge after the load.
        for (int k = 1; k <= 6; k++) begin
            step(8'h01, 8'hF2, 1'b0);
            chk($sformatf("dwell%0d_code", k), code_out, (k >= 5) ? 32'h3 : 32'h0);
            chk($sformatf("dwell%0d_seen", k), {24'h0, seen}, (k >= 5) ? 32'h1 : 32'h0);
            chk($sformatf("dwell%0d_frame", k), {31'h0, frame_done}, 32'h0);
        end

        // Table rows; the toggle sequence runs between the scans and the error rows.
        for (int r = 0; r < 21; r++) begin
            frames = 0;
            for (int k = 0; k < vt[r].cyc; k++) begin
                step(vt[r].dig, vt[r].ssd, vt[r].clr);
                if (frame_done) frames++;
            end
            chk($sformatf("row%0d_code", r), code_out, vt[r].code);
            chk($sformatf("row%0d_seen", r), {24'h0, seen}, {24'h0, vt[r].seen});
            chk($sformatf("row%0d_bad", r), {24'h0, bad_seg}, {24'h0, vt[r].bad});
            chk($sformatf("row%0d_oherr", r), {31'h0, onehot_err}, {31'h0, vt[r].oherr});
            chk($sformatf("row%0d_frames", r), frames, vt[r].frames);
            if (r == 16) begin
                // Segments change every 2 clocks: never settles.
                for (int k = 0; k < 12; k++) step(8'h04, (k % 4 < 2) ? 8'hDA : 8'h66, 1'b0);
                chk("toggle_code", code_out, 32'h7654_3210);
                chk("toggle_seen", {24'h0, seen}, 32'hFF);
            end
        end

        // Reset in the middle of a dwell: a full settle time is needed again.
        for (int k = 0; k < 3; k++) step(8'h08, 8'hB6, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_code", code_out, 32'h0);
        chk("rst_seen", {24'h0, seen}, 32'h0);
        #12;
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 5; k++) begin
            step(8'h08, 8'hB6, 1'b0);
            chk($sformatf("rdwell%0d_seen", k), {24'h0, seen}, (k == 5) ? 32'h08 : 32'h00);
        end
        chk("rdwell_code", code_out, 32'h0000_5000);

`ifdef SSD_SCAN_TIMEOUT_EN
        // Stop scanning after the capture above; the model tracks the stall pulse.
        for (int k = 0; k < 70; k++) step(8'h00, 8'h00, 1'b0);
        chk("timeout_seen", {24'h0, seen}, 32'h0);
`endif

        // Random dwells against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       d = 8'h00;
                1:       d = 8'($urandom_range(0, 255));
                default: d = 8'h01 << $urandom_range(0, 7);
            endcase
            if ($urandom_range(0, 5) == 0) s = 8'($urandom_range(0, 255));
            else s = {seg_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                c = ($urandom_range(0, 60) == 0);
                step(d, s, c);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
Receive-side companion to the pad counter's multiplexed seven-segment display drive. Watches the scanned digit-select and segment buses and waits for each digit to settle. Decodes each settled segment pattern back to a 4-bit hex code and holds a per-digit register image. Used on-chip for self-check and by benches to read displayed values without decoding waveforms by eye.

Parameters:
N_DIG, 8, number of digit positions; width of dig.
SETTLE_CYC, 4, consecutive stable clock edges required before a capture; legal range 1..15.
TIMEOUT_CYC, 1024, watchdog length in clocks; used only with SSD_SCAN_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
dig  in  N_DIG  digit select, active-high one-hot; all-zero means blank.
ssd  in  8  segments, active-high: ssd[7:1] = a,b,c,d,e,f,g; ssd[0] = dp.
clr  in  1  synchronous clear of captured state.
code_out  out  4*N_DIG  decoded hex per digit; digit i at [4i+3:4i].
dp_out  out  N_DIG  captured dp per digit.
seen  out  N_DIG  digit captured at least once since reset/clr.
bad_seg  out  N_DIG  last capture of digit i had an undecodable pattern.
frame_done  out  1  one-cycle pulse on scan wrap.
onehot_err  out  1  sticky: settled dig had more than one bit set.
stall  out  1  present only with SSD_SCAN_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, stable counter 0, last-index register invalid. dig and ssd are already in the clk domain; no synchroniser.
- Sample stage: {dig,ssd} is registered each edge. The stable counter increments, saturating at SETTLE_CYC, when the new sample equals the previous sample. It loads 0 on any difference.
- Settle event: occurs on the edge where the counter reaches SETTLE_CYC. There is exactly one settle event per dwell. Outputs update at that edge.
- Settle event, dig all-zero: no action.
- Settle event, dig one-hot at index i:
  - dp_out[i] <= ssd[0]; seen[i] <= 1.
  - code_out[i] <= decode(ssd[7:1]).
  - bad_seg[i] <= 1 if the pattern is not in the decode table. code_out[i] is then left unchanged.
- Settle event, dig with two or more bits set: onehot_err <= 1 (sticky). No capture, and last index is not updated.
- Decode table, a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Any other pattern (including all-off) is bad.
- frame_done: pulses on the capture edge of index i when the last index is valid and i <= last index (scan wrapped, or the same digit was re-dwelt). After the check, last index <= i.
- Wrap in either scan direction: ascending scans pulse once per frame. A descending scan pulses on every capture; this is documented, not an error.
- clr=1: at the edge, code_out, dp_out, seen, bad_seg and onehot_err are cleared, and last index becomes invalid. The stable counter is unaffected.
- Simultaneous clr and settle event: clr wins and the capture is discarded.
- Reset mid-dwell: counter restarts from 0 after release. A full SETTLE_CYC is needed again.

Optional Feature:
SSD_SCAN_TIMEOUT_EN defined:
- The watchdog counts clocks since the last capture.
- Reaching TIMEOUT_CYC: pulse stall for 1 cycle, clear seen, invalidate last index, restart the count.
- Capture or clr resets the count to 0.
- Blank dwells do not reset the count.

SSD_SCAN_TIMEOUT_EN undefined: no stall port, no watchdog logic, seen only clears on reset/clr.

Test Plan:
- Reset then hold dig=00000001, ssd=1111001_0 for 6 clocks (SETTLE_CYC=4):
  - code_out[3:0]=3 and seen=01 appear exactly on the 4th stable edge after the sample register loads.
  - No earlier update; no second update on clocks 5–6.
- Scan digits 0..7 showing 0..7 at 8 clocks each, then repeat the scan:
  - code_out=32'h76543210, seen=8'hFF.
  - frame_done pulses once, at the digit-0 capture of the 2nd scan.
- Toggle ssd every 2 clocks while dig=00000100: no capture, code_out and seen unchanged.
- dig=00000011 held 8 clocks: onehot_err=1, seen unchanged. Then clr=1 for 1 clock: onehot_err=0.
- dig=00000010 with ssd a..g=1010101 settled: bad_seg[1]=1, code_out[7:4] keeps its prior value. Then valid '9': bad_seg[1]=0, code_out[7:4]=9.
- With SSD_SCAN_TIMEOUT_EN and TIMEOUT_CYC=64, stop scanning after one capture: stall pulses 64 clocks after that capture, and seen=0.
